coriolis_fpmul_share_ctrl: RTL and testbench
============================================

Name: coriolis_fpmul_share_ctrl

Overview:
- Time-multiplexes one pipelined FloPoCo FP multiplier (STREAMW-bit FloPoCo format, 2 exception bits + IEEE single) among NREQ requester streams.
- Round-robin arbitration: at most one operand pair issued per advancing cycle.
- Carries a requester-ID tag alongside the multiplier pipeline and routes each product back to its originating requester with valid/ready handshake.
- Sits between kernel map nodes and a single multiplier instance. Saves DSPs where several leaf multiplies run below one result per cycle each.

Parameters:
- STREAMW, 34, operand/result width (FloPoCo format).
- NREQ, 3, number of requesters (2..8).
- LAT, 3, multiplier latency in advancing (non-stalled) cycles (1..8).
- IDW, clog2(NREQ), tag width (derived, localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_x  in  NREQ*STREAMW  X operands, requester i at bits [i*STREAMW +: STREAMW]
- req_y  in  NREQ*STREAMW  Y operands, same packing
- mul_x  out  STREAMW  to multiplier X
- mul_y  out  STREAMW  to multiplier Y
- mul_stall  out  1  to multiplier stall; high freezes its pipeline
- mul_r  in  STREAMW  multiplier result, valid when tail tag valid
- res_valid  out  NREQ  one-hot result valid to owning requester
- res_data  out  STREAMW  result data, shared by all requesters
- res_ready  in  NREQ  per-requester result accept
- issue_cnt  out  32  count of accepted operand pairs; wraps modulo 2^32

Behaviour:
- Tag pipeline: LAT stages of {tv, tid}. Stage LAT-1 is the tail, aligned with mul_r.
- adv = ~tv[LAT-1] | res_ready[tid[LAT-1]]. mul_stall = ~adv.
- Tag stages shift only when adv; otherwise all hold.
- Grant (combinational):
  - Search order is ptr, ptr+1, …, NREQ-1, 0, … ptr-1.
  - g = first i in that order with req_valid[i].
  - gv = |req_valid.
- req_ready[g] = adv & gv; all other bits 0.
- Handshake fires on req_valid & req_ready.
- mul_x/mul_y = req_x/req_y of g when gv, else 0. The multiplier sees these only when adv.
- On adv:
  - tv[0] <= gv, tid[0] <= g. Idle cycles insert bubbles (tv=0).
  - Stage k <= stage k-1.
- ptr update:
  - On adv & gv: ptr <= (g+1) mod NREQ.
  - Otherwise ptr holds, including while stalled and while idle.
- Output:
  - res_valid = tv[LAT-1] ? onehot(tid[LAT-1]) : 0.
  - res_data = mul_r (unregistered pass-through).
  - Result consumed when res_valid & res_ready of the owner.
- Backpressure: only the owner's res_ready matters. Other requesters' res_ready is ignored.
  - Head-of-line blocking is accepted: a stalled tail blocks all requesters.
- Same-cycle events: result retire and new issue occur in the same cycle when adv. Full throughput is 1 product/cycle.
- Latency: issue at cycle t with no stalls → res_valid asserted at cycle t+LAT.
  - Each stall cycle adds 1 cycle.
- Ordering: results return in issue order. A requester must not depend on interleaving with others.
- issue_cnt increments by 1 on each handshake. It wraps from 0xFFFFFFFF to 0.
- Reset (sync, rst high at posedge):
  - tv all 0, tid 0, ptr 0, issue_cnt 0.
  - Outputs during and after reset: req_ready per grant logic (adv=1 since tail empty), res_valid 0, mul_stall 0.
  - rst mid-operation discards all in-flight products; none is delivered.
  - Requesters re-present after reset.
  - The multiplier's own rst is driven from the same rst.
- req_valid on an index >= NREQ does not exist; NREQ=1 degenerates to pass-through with ptr fixed at 0.

Decomposition:
- Shared package coriolis_pkg:
  - STREAMW default.
  - FPC_EXC_NORMAL = 2'b01.
  - clog2 function.
  - LAT constants of the FloPoCo units (FPMULT_LAT=3).
- One natural sub-module: coriolis_rr_arbiter. Holds ptr and combinational grant, with inputs req, adv and outputs g, gv.
- The multiplier instance stays outside, in the kernel top.

Test Plan:
- Single requester 0, x=34'h1_40000000 (2.0), y=34'h1_40400000 (3.0), all res_ready=1 → req_ready[0]=1 same cycle; res_valid=3'b001 exactly 3 cycles later, res_data=34'h1_40C00000 (6.0); issue_cnt=1.
- All 3 requesters valid continuously, res_ready=all 1 → grants in order 0,1,2,0,1,2; one result per cycle from cycle 3; each res_valid one-hot matching its issue order.
- Requesters 0,1 in flight; res_ready[0]=0 for 4 cycles while the tail belongs to requester 0 → mul_stall=1 and all req_ready=0 for those 4 cycles; tail holds; res_ready[1]=1 has no effect; the resume delivers in order.
- Requester 2 valid only, ptr=0 → immediate grant to 2, ptr becomes 0; then requesters 0 and 2 both valid → grant 0.
- rst asserted with 2 products in flight → no res_valid after reset, issue_cnt=0, next grant goes to requester 0.
- issue_cnt preloaded via force to 0xFFFFFFFF, one handshake → issue_cnt=0.

Source files
------------

// File: rtl/coriolis_pkg.sv
// Shared constants and types for the coriolis FloPoCo datapath blocks.
// FloPoCo words carry 2 exception bits above an IEEE single.
package coriolis_pkg;

    localparam int STREAMW_DEF = 34;
    localparam logic [1:0] FPC_EXC_NORMAL = 2'b01;
    localparam int FPMULT_LAT = 3;
    localparam int TIDW_MAX = 3;

    // One slot of the requester-tag pipeline that shadows the multiplier.
    typedef struct packed {
        logic                vld;
        logic [TIDW_MAX-1:0] id;
    } fpm_tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/coriolis_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the search starts at ptr and the
// pointer moves past the winner only when a grant is actually taken.
module coriolis_rr_arbiter
    import coriolis_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [IDW-1:0]  g,
    output logic            gv
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] rot;
    logic [IDW:0]    sum;
    logic            found;

    // rot[k] is requester (ptr+k) mod NREQ, so the first set bit is the winner.
    always_comb begin
        rot   = NREQ'(({req, req} >> ptr));
        g     = '0;
        sum   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ))
                    sum = sum - (IDW+1)'(NREQ);
                g = sum[IDW-1:0];
            end
        end
        gv = |req;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv && gv)
            ptr <= (g == IDW'(NREQ-1)) ? '0 : g + IDW'(1);
    end

endmodule

// File: rtl/coriolis_fpmul_share_ctrl.sv
// Shares one pipelined FloPoCo multiplier among NREQ streams; a tag pipeline
// tracks which requester owns each in-flight product and steers it back.
module coriolis_fpmul_share_ctrl
    import coriolis_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int NREQ    = 3,
    parameter int LAT     = FPMULT_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*STREAMW-1:0] req_x,
    input  logic [NREQ*STREAMW-1:0] req_y,
    output logic [STREAMW-1:0]      mul_x,
    output logic [STREAMW-1:0]      mul_y,
    output logic                    mul_stall,
    input  logic [STREAMW-1:0]      mul_r,
    output logic [NREQ-1:0]         res_valid,
    output logic [STREAMW-1:0]      res_data,
    input  logic [NREQ-1:0]         res_ready,
    output logic [31:0]             issue_cnt
);

    localparam int IDW = (NREQ > 1) ? clog2(NREQ) : 1;

    logic [IDW-1:0] g;
    logic           gv;
    logic           adv;
    logic [31:0]    issue_cnt_q;
    fpm_tag_t       tags [LAT];

    coriolis_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (adv),
        .g   (g),
        .gv  (gv)
    );

    // Only the tail owner's ready can hold the pipe; a stalled tail blocks everyone.
    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NREQ; i++)
            if (tags[LAT-1].vld && tags[LAT-1].id == TIDW_MAX'(i))
                res_valid[i] = 1'b1;
        adv       = !tags[LAT-1].vld || |(res_valid & res_ready);
        mul_stall = !adv;
    end

    always_comb begin
        req_ready = '0;
        mul_x     = '0;
        mul_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gv && g == IDW'(i)) begin
                req_ready[i] = adv;
                mul_x        = req_x[i*STREAMW +: STREAMW];
                mul_y        = req_y[i*STREAMW +: STREAMW];
            end
        end
    end

    // Idle advancing cycles push bubbles so tags stay aligned with mul_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++)
                tags[k] <= '0;
        end else if (adv) begin
            tags[0] <= '{vld: gv, id: TIDW_MAX'(g)};
            for (int k = 1; k < LAT; k++)
                tags[k] <= tags[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            issue_cnt_q <= '0;
        else if (adv && gv)
            issue_cnt_q <= issue_cnt_q + 32'd1;
    end

    assign res_data  = mul_r;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_coriolis_fpmul_share_ctrl.sv
// Bench for coriolis_fpmul_share_ctrl: a stalling multiplier model behind the
// DUT, a per-cycle directed table, and a scoreboard checked by a result monitor.
module tb_coriolis_fpmul_share_ctrl;
    import coriolis_pkg::*;

    localparam int STREAMW = 34;
    localparam int NREQ    = 3;
    localparam int LAT     = 3;

    typedef struct packed {
        logic [NREQ-1:0]    vld;
        logic [STREAMW-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*STREAMW-1:0] req_x;
    logic [NREQ*STREAMW-1:0] req_y;
    logic [STREAMW-1:0]      mul_x;
    logic [STREAMW-1:0]      mul_y;
    logic                    mul_stall;
    logic [STREAMW-1:0]      mul_r;
    logic [NREQ-1:0]         res_valid;
    logic [STREAMW-1:0]      res_data;
    logic [NREQ-1:0]         res_ready;
    logic [31:0]             issue_cnt;

    logic [STREAMW-1:0] exp_r [NREQ];
    logic [STREAMW-1:0] mpipe [LAT];
    exp_t               sb_q [$];
    int                 checks   = 0;
    int                 failures = 0;

    coriolis_fpmul_share_ctrl #(.STREAMW(STREAMW), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_stall (mul_stall),
        .mul_r     (mul_r),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Normal-number multiply, exact for the operand pairs used here.
    function automatic logic [STREAMW-1:0] fpmul(input logic [STREAMW-1:0] a, input logic [STREAMW-1:0] b);
        logic [47:0] p;
        logic [8:0]  e;
        logic [22:0] m;
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 9'd1;
        end else begin
            m = p[45:23];
        end
        return {FPC_EXC_NORMAL, a[31] ^ b[31], e[7:0], m};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) mpipe[k] <= '0;
        end else if (!mul_stall) begin
            mpipe[0] <= fpmul(mul_x, mul_y);
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_r = mpipe[LAT-1];

    task automatic chk(input string nm, input logic [STREAMW-1:0] act, input logic [STREAMW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [STREAMW-1:0] x, input logic [STREAMW-1:0] y,
                           input logic [STREAMW-1:0] r);
        req_x[i*STREAMW +: STREAMW] = x;
        req_y[i*STREAMW +: STREAMW] = y;
        exp_r[i] = r;
    endtask

    // One cycle of the directed table: drive, check at negedge, log expected product.
    task automatic step(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] exp_rdy,
                        input logic [NREQ-1:0] rr, input logic exp_stall,
                        input logic [NREQ-1:0] exp_rv);
        exp_t e;
        req_valid = mask;
        res_ready = rr;
        @(negedge clk);
        chk("req_ready", STREAMW'(req_ready), STREAMW'(exp_rdy));
        chk("mul_stall", STREAMW'(mul_stall), STREAMW'(exp_stall));
        chk("res_valid", STREAMW'(res_valid), STREAMW'(exp_rv));
        if (exp_rdy != '0) begin
            e.vld = exp_rdy;
            e.data = '0;
            for (int i = 0; i < NREQ; i++)
                if (exp_rdy[i]) e.data = exp_r[i];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Second reset cycle presents requester 1 to show the grant stays live in reset.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = '0;
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        @(negedge clk);
        chk("rst_res_valid", STREAMW'(res_valid), '0);
        chk("rst_mul_stall", STREAMW'(mul_stall), '0);
        chk("rst_req_ready", STREAMW'(req_ready), STREAMW'(3'b010));
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        sb_q.delete();
        chk("rst_issue_cnt", STREAMW'(issue_cnt), '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%b required=none t=%0t", res_valid, $time);
            end else if ((res_valid & res_ready) != '0) begin
                e = sb_q.pop_front();
                chk("sb_owner", STREAMW'(res_valid), STREAMW'(e.vld));
                chk("sb_data", res_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        res_ready = '0;
        req_x = '0;
        req_y = '0;
        set_ops(0, 34'h1_40000000, 34'h1_40400000, 34'h1_40C00000); // 2.0*3.0
        set_ops(1, 34'h1_3FC00000, 34'h1_40000000, 34'h1_40400000); // 1.5*2.0
        set_ops(2, 34'h1_40800000, 34'h1_3F000000, 34'h1_40000000); // 4.0*0.5
        do_reset();

        // Single requester, latency of LAT cycles.
        step(3'b001, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b001);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        chk("issue_cnt_single", STREAMW'(issue_cnt), STREAMW'(1));

        // Full-rate round robin.
        do_reset();
        set_ops(1, 34'h1_40400000, 34'h1_40400000, 34'h1_41100000); // 3.0*3.0
        step(3'b111, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b111, 3'b010, 3'b111, 1'b0, 3'b000);
        step(3'b111, 3'b100, 3'b111, 1'b0, 3'b000);
        step(3'b111, 3'b001, 3'b111, 1'b0, 3'b001);
        step(3'b111, 3'b010, 3'b111, 1'b0, 3'b010);
        step(3'b111, 3'b100, 3'b111, 1'b0, 3'b100);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b001);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b010);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b100);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        chk("issue_cnt_rr", STREAMW'(issue_cnt), STREAMW'(6));

        // Owner backpressure on the tail for 4 cycles; other readies ignored.
        do_reset();
        step(3'b001, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b010, 3'b010, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        repeat (4) step(3'b100, 3'b000, 3'b110, 1'b1, 3'b001);
        step(3'b100, 3'b100, 3'b111, 1'b0, 3'b001);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b010);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b100);

        // Pointer wrap: grant 2 leaves ptr at 0, so 0 wins over 2 next.
        do_reset();
        step(3'b100, 3'b100, 3'b111, 1'b0, 3'b000);
        step(3'b101, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b100, 3'b100, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b100);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b001);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b100);

        // Reset with two products in flight: both dropped, ptr back to 0.
        step(3'b001, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b010, 3'b010, 3'b111, 1'b0, 3'b000);
        do_reset();
        step(3'b111, 3'b001, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b001);

        // Issue counter wrap.
        force dut.issue_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.issue_cnt_q;
        step(3'b010, 3'b010, 3'b111, 1'b0, 3'b000);
        chk("issue_cnt_wrap", STREAMW'(issue_cnt), '0);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b010);
        step(3'b000, 3'b000, 3'b111, 1'b0, 3'b000);

        chk("sb_drained", STREAMW'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
